// File: rtl/stream_merge_pkg.sv
// Shared definitions for the round-robin stream merger.
//   ARB / LOCK : arbitration FSM state encodings
//   clog2      : index width for a channel count (minimum 1)
//   ch_lsb     : LSB position of a channel's slice in a flattened bus
package stream_merge_pkg;

  localparam logic [0:0] ARB  = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/stream_merge_rr_arbiter.sv
// Combinational rotating-priority encoder.
//   req         : per-channel request vector
//   ptr         : channel holding highest priority this cycle
//   grant       : first requester found searching ptr, ptr+1, ... (mod N_CH)
//   grant_valid : at least one channel is requesting
module rr_arbiter
  import stream_merge_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CHW  = clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CHW-1:0]  ptr,
  output logic [CHW-1:0]  grant,
  output logic            grant_valid
);

  // Each requester's distance from ptr in the rotated order; the smallest
  // distance wins. Iterating over constant channel indices keeps every
  // select static.
  int best_d;
  int d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant       = '0;
    grant_valid = 1'b0;
    best_d      = N_CH;
    d           = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (req[i]) begin
        d = (i + N_CH - int'(ptr)) % N_CH;
        if (d < best_d) begin
          best_d      = d;
          grant       = CHW'(i);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_merge_rr.sv
// N-channel round-robin stream merger with optional packet lock and a
// sticky exception aggregator.
//   input_data/stb/last/ack : N_CH upstream stb/ack streams (flattened data)
//   output_data/stb/last    : registered merged stream, output_ack accepts
//   output_channel          : source channel of the current output word
//   exception_in/_clear     : per-channel exception flags, sticky clear
//   exception/exception_src : sticky OR and first raising channel
module stream_merge_rr
  import stream_merge_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int WIDTH       = 32,
  parameter int PACKET_MODE = 0,
  parameter int CHW         = clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] input_data,
  input  logic [N_CH-1:0]       input_stb,
  output logic [N_CH-1:0]       input_ack,
  input  logic [N_CH-1:0]       input_last,
  output logic [WIDTH-1:0]      output_data,
  output logic                  output_stb,
  input  logic                  output_ack,
  output logic                  output_last,
  output logic [CHW-1:0]        output_channel,
  input  logic [N_CH-1:0]       exception_in,
  input  logic                  exception_clear,
  output logic                  exception,
  output logic [CHW-1:0]        exception_src
);

  logic [0:0]       state;
  logic [CHW-1:0]   ptr;
  logic [CHW-1:0]   lock_ch;
  logic [CHW-1:0]   arb_grant;
  logic             arb_valid;
  logic [CHW-1:0]   grant;
  logic [WIDTH-1:0] sel_data;
  logic             sel_stb;
  logic             sel_last;
  logic             can_load;
  logic             accept;
  logic [N_CH-1:0]  sticky;
  logic [N_CH-1:0]  sticky_base;
  logic [N_CH-1:0]  sticky_nxt;
  logic [CHW-1:0]   exc_low;

  function automatic logic [CHW-1:0] next_ch(input logic [CHW-1:0] ch);
    return (ch == CHW'(N_CH - 1)) ? '0 : ch + CHW'(1);
  endfunction

  rr_arbiter #(.N_CH(N_CH), .CHW(CHW)) u_arb (
    .req         (input_stb),
    .ptr         (ptr),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  // In LOCK the grant is pinned to the packet owner even when it idles, so
  // other channels cannot slip words into the middle of a packet.
  always_comb begin
    grant    = (state == LOCK) ? lock_ch : arb_grant;
    sel_data = '0;
    sel_stb  = 1'b0;
    sel_last = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == CHW'(i)) begin
        sel_data = input_data[ch_lsb(i, WIDTH) +: WIDTH];
        sel_stb  = input_stb[i];
        sel_last = input_last[i];
      end
    end
    can_load = !output_stb || output_ack;
    // rst gates accept so input_ack reads 0 while reset is held.
    accept = rst && can_load && sel_stb && (arb_valid || state == LOCK);
    for (int i = 0; i < N_CH; i++) begin
      input_ack[i] = accept && (grant == CHW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state   <= ARB;
      ptr     <= '0;
      lock_ch <= '0;
    end else if (accept) begin
      if (state == ARB) begin
        ptr <= next_ch(grant);
        if (PACKET_MODE != 0 && !sel_last) begin
          state   <= LOCK;
          lock_ch <= grant;
        end
      end else if (sel_last) begin
        state <= ARB;
        ptr   <= next_ch(lock_ch);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      output_data    <= '0;
      output_stb     <= 1'b0;
      output_last    <= 1'b0;
      output_channel <= '0;
    end else if (accept) begin
      output_data    <= sel_data;
      output_stb     <= 1'b1;
      output_last    <= sel_last;
      output_channel <= grant;
    end else if (output_ack) begin
      output_stb <= 1'b0;
    end
  end

  // Clear and new flags on the same edge: clear removes old state first,
  // then new flags re-latch, so a simultaneous event is never lost.
  always_comb begin
    sticky_base = exception_clear ? '0 : sticky;
    sticky_nxt  = sticky_base | exception_in;
    exc_low     = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (exception_in[i]) exc_low = CHW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky        <= '0;
      exception     <= 1'b0;
      exception_src <= '0;
    end else begin
      sticky    <= sticky_nxt;
      exception <= |sticky_nxt;
      if (sticky_base == '0 && exception_in != '0) begin
        exception_src <= exc_low;
      end else if (exception_clear) begin
        exception_src <= '0;
      end
    end
  end

endmodule

// File: doc/stream_merge_rr.md
Name: stream_merge_rr

Overview:
- Parametrised N-channel stream merger for the top-level user design.
- Round-robin arbitrates N stb/ack input streams onto one stb/ack output stream.
- Optional packet mode holds the grant until end-of-packet.
- Aggregates per-process exception flags into a sticky, clearable exception with first-source capture. Replaces the plain combinational exception OR.

Parameters:
- N_CH, 4, number of input channels (2..16).
- WIDTH, 32, data width per channel.
- PACKET_MODE, 0; 0 = re-arbitrate every word, 1 = hold grant until a word with last=1 is accepted.
- CHW, clog2(N_CH), width of channel index fields.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- input_data  in  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- input_stb  in  N_CH  per-channel data valid.
- input_ack  out  N_CH  per-channel accept; at most one bit high.
- input_last  in  N_CH  per-channel end-of-packet, qualified by stb.
- output_data  out  WIDTH  merged data (registered).
- output_stb  out  1  output valid (registered).
- output_ack  in  1  downstream accept.
- output_last  out  1  end-of-packet of the current output word.
- output_channel  out  CHW  source channel of the current output word.
- exception_in  in  N_CH  per-process exception flags.
- exception_clear  in  1  single-cycle clear of sticky exception state.
- exception  out  1  sticky OR of latched exceptions.
- exception_src  out  CHW  index of the first channel to raise an exception.

Behaviour:
- Transfer rule: a word moves when stb and ack are both 1 at a rising clk edge. Upstream holds stb and data stable until acked.
- Reset (rst=0, async): all outputs 0, including output_stb, output_data, output_last, output_channel, input_ack, exception and exception_src. State = ARB. RR pointer = 0, so channel 0 has highest priority first.
- Output register "can load" = !output_stb || output_ack.
- input_ack is combinational: onehot(grant) when can-load and the granted channel has stb=1, else 0.
- The accepting edge loads data, last and channel into the output register and sets output_stb=1.
- output_stb clears on an output_ack edge unless a new word loads on the same edge.
- Sustained throughput is 1 word/cycle when output_ack is held at 1.
- Latency: input accept edge to output_stb=1 is one edge.
- ARB state:
  - grant = first requesting channel searching from ptr, ptr+1, … wrapping modulo N_CH.
  - On accept, ptr <= grant+1 (wraps N_CH-1 → 0).
  - If PACKET_MODE=1 and last=0, go to LOCK with lock_ch = grant.
  - No requests: input_ack = 0, state unchanged.
- LOCK state (PACKET_MODE=1 only):
  - grant fixed to lock_ch; other channels are never acked, even if lock_ch's stb is low.
  - When a word with last=1 is accepted, go to ARB with ptr = lock_ch+1.
- PACKET_MODE=0: LOCK is unreachable, and input_last is passed through to output_last only.
- Exceptions:
  - sticky[i] sets on exception_in[i]=1; exception = |sticky, registered, one-cycle latency.
  - exception_src is captured on the edge where sticky goes from all-zero to nonzero. If several bits rise simultaneously, the lowest index wins. Later sources do not overwrite it.
  - exception_clear=1 zeroes sticky and exception_src on that edge. If exception_in is also high on that edge, set wins: sticky re-latches and exception_src records the new lowest source.
- Reset mid-packet: LOCK is abandoned and the output word is dropped. Upstream is responsible for restarting the packet.
- Requester dropping stb without ack is illegal upstream behaviour. The arbiter simply re-evaluates the grant the next cycle.

Decomposition:
- Package stream_merge_pkg: state enum {ARB, LOCK}, clog2 function, channel-index slice helper.
- Sub-module rr_arbiter (N_CH, CHW):
  - Inputs: req vector, ptr.
  - Outputs: grant index, grant_valid.
  - Purely combinational rotate-priority encoder.
- Parent stream_merge_rr holds the pointer, lock FSM, output register and exception logic.

Test Plan:
- Reset: assert rst=0 mid-traffic (N_CH=4) -> all outputs 0 immediately (async); first grant after release goes to channel 0.
- Fairness: all 4 stb=1 continuously, output_ack=1, PACKET_MODE=0 -> output_channel sequence 0,1,2,3,0,1… with one word per cycle.
- Wrap and idle skip: ptr=3, only channels 1 and 3 request -> order 3,1,3,1; channels 0 and 2 are never acked.
- Backpressure: output_ack=0 for 5 cycles with channel 2 requesting -> exactly one word accepted and output_data stable; input_ack=0 for the remaining cycles.
- Packet lock: PACKET_MODE=1; channel 1 sends 3 words (last on the 3rd) while channel 0 requests -> output shows 1,1,1 then 0; channel 0 is not acked during the packet.
- Exceptions: exception_in=4'b0110 on one edge -> exception=1, exception_src=1. exception_in[3] later leaves src at 1. exception_clear with exception_in[3]=1 on the same edge -> exception stays 1, src=3.
